// File: rtl/cpc_mem_pkg.sv
// Shared definitions for the CPC RAM arbiter: FSM encoding, byte-enable codes, address widths.
package cpc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_CPU  = 2'd2
    } state_e;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    localparam int unsigned ADDR_W_DEF = 22;
    localparam int unsigned CPU_WA_W   = 22;

    function automatic logic [1:0] be_for_lane(input logic lane);
        return lane ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/cpc_rdcache.sv
// One-entry CPU read cache: a single tagged 16-bit word, filled on read misses and kept
// coherent with CPU byte writes to the same word.
module cpc_rdcache
    import cpc_mem_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CPU_WA_W-1:0] lookup_addr_i,
    output logic                hit_o,
    output logic [15:0]         hit_data_o,
    input  logic                fill_i,
    input  logic                wr_i,
    input  logic [CPU_WA_W-1:0] upd_addr_i,
    input  logic [15:0]         fill_data_i,
    input  logic                wr_lane_i,
    input  logic [7:0]          wr_data_i
);

    logic                valid_q;
    logic [CPU_WA_W-1:0] tag_q;
    logic [15:0]         data_q;

    assign hit_o      = valid_q && (tag_q == lookup_addr_i);
    assign hit_data_o = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= upd_addr_i;
            data_q  <= fill_data_i;
        end else if (wr_i && valid_q && (tag_q == upd_addr_i)) begin
            if (wr_lane_i) begin
                data_q[15:8] <= wr_data_i;
            end else begin
                data_q[7:0] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/cpc_ram_arbiter.sv
// Serialises CPU byte accesses and gate-array video word fetches onto one 16-bit RAM
// req/ack port, video first. Define CPC_RAM_RDCACHE_EN to add a one-entry CPU read cache.
module cpc_ram_arbiter
    import cpc_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] VID_BASE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [14:0]       vram_addr,
    output logic [15:0]       vram_din,
    input  logic [22:0]       mem_addr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_busy,
    output logic              ram_req,
    output logic              ram_we,
    output logic [1:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    input  logic              ram_ack
);

    state_e              state_q;
    logic                rw_prev_q;
    logic                vid_pend_q;
    logic [14:0]         vid_addr_q;
    logic                cpu_pend_q;
    logic [CPU_WA_W-1:0] cpu_waddr_q;
    logic                cpu_lane_q;
    logic                cpu_we_q;
    logic [7:0]          cpu_data_q;
    logic [15:0]         vram_din_q;
    logic [7:0]          cpu_din_q;
    logic                ram_req_q;
    logic                ram_we_q;
    logic [1:0]          ram_be_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [15:0]         ram_wdata_q;

    logic        rw_lvl;
    logic        rw_edge;
    logic        cache_hit;
    logic [15:0] cache_data;
    logic        rd_hit;
    logic        cpu_accept;
    logic        vid_issue;
    logic        cpu_issue;
    logic        cpu_ack;

    assign rw_lvl    = mem_rd | mem_wr;
    assign rw_edge   = rw_lvl & ~rw_prev_q;
    assign vid_issue = (state_q == ST_IDLE) & vid_pend_q;
    assign cpu_issue = (state_q == ST_IDLE) & ~vid_pend_q & cpu_pend_q;
    assign cpu_ack   = (state_q == ST_CPU) & ram_ack;

`ifdef CPC_RAM_RDCACHE_EN
    cpc_rdcache u_rdcache (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .lookup_addr_i(mem_addr[22:1]),
        .hit_o        (cache_hit),
        .hit_data_o   (cache_data),
        .fill_i       (cpu_ack & ~cpu_we_q),
        .wr_i         (cpu_ack & cpu_we_q),
        .upd_addr_i   (cpu_waddr_q),
        .fill_data_i  (ram_rdata),
        .wr_lane_i    (cpu_lane_q),
        .wr_data_i    (cpu_data_q)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = 16'h0000;
`endif

    // A read hit is absorbed here and never becomes a pending RAM access.
    assign rd_hit     = rw_edge & ~mem_wr & ~cpu_pend_q & cache_hit;
    assign cpu_accept = rw_edge & ~cpu_pend_q & ~rd_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rw_prev_q   <= 1'b0;
            vid_pend_q  <= 1'b0;
            vid_addr_q  <= '0;
            cpu_pend_q  <= 1'b0;
            cpu_waddr_q <= '0;
            cpu_lane_q  <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_data_q  <= '0;
            vram_din_q  <= '0;
            cpu_din_q   <= 8'hFF;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            rw_prev_q <= rw_lvl;

            // A new strobe wins over the issue-clear so back-to-back fetches are not lost.
            if (vid_req) begin
                vid_pend_q <= 1'b1;
                vid_addr_q <= vram_addr;
            end else if (vid_issue) begin
                vid_pend_q <= 1'b0;
            end

            if (cpu_accept) begin
                cpu_pend_q  <= 1'b1;
                cpu_waddr_q <= mem_addr[22:1];
                cpu_lane_q  <= mem_addr[0];
                cpu_we_q    <= mem_wr;
                cpu_data_q  <= cpu_dout;
            end else if (cpu_issue) begin
                cpu_pend_q <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (vid_pend_q) begin
                        state_q    <= ST_VID;
                        ram_req_q  <= 1'b1;
                        ram_we_q   <= 1'b0;
                        ram_be_q   <= BE_WORD;
                        ram_addr_q <= VID_BASE + ADDR_W'(vid_addr_q);
                    end else if (cpu_pend_q) begin
                        state_q     <= ST_CPU;
                        ram_req_q   <= 1'b1;
                        ram_we_q    <= cpu_we_q;
                        ram_be_q    <= cpu_we_q ? be_for_lane(cpu_lane_q) : BE_WORD;
                        ram_addr_q  <= ADDR_W'(cpu_waddr_q);
                        ram_wdata_q <= {cpu_data_q, cpu_data_q};
                    end
                end
                ST_VID: begin
                    if (ram_ack) begin
                        state_q    <= ST_IDLE;
                        ram_req_q  <= 1'b0;
                        vram_din_q <= ram_rdata;
                    end
                end
                ST_CPU: begin
                    if (ram_ack) begin
                        state_q   <= ST_IDLE;
                        ram_req_q <= 1'b0;
                        if (!cpu_we_q) begin
                            cpu_din_q <= cpu_lane_q ? ram_rdata[15:8] : ram_rdata[7:0];
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ram_req_q <= 1'b0;
                end
            endcase

            // Placed last so a fresh hit overrides an older read completing this cycle.
            if (rd_hit) begin
                cpu_din_q <= mem_addr[0] ? cache_data[15:8] : cache_data[7:0];
            end
        end
    end

    assign vram_din  = vram_din_q;
    assign cpu_din   = cpu_din_q;
    assign cpu_busy  = cpu_pend_q | (state_q == ST_CPU);
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_be    = ram_be_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule
